ro_stress_bank: RTL

Parametrised, programmable successor to the single-instance ring-oscillator core. It instantiates `NUM_BANKS × BANK_SIZE` `ro_fanout` cells and drives one enable per bank from a sequencer. The sequencer produces timed on/off bursts with an optional per-bank ramp-up, for controlled on-die power and voltage stress in the sensors subsystem. Configuration is latched at start, so software can reprogram the inputs while a run is in progress.

---
 rtl/ro_stress_bank.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ro_stress_bank.sv
// Bank-sequenced RO stress array: start-latched config drives timed ON/OFF bursts with optional per-bank ramp.
// Outputs registered, one-cycle start-to-enable latency; no backpressure (start ignored while busy, stop always wins).

module ro_fanout (
    input  logic R_in,
    output logic R_out
);
    (* keep = "true", s = "true" *) logic q_out;

    assign q_out = ~R_in;
    assign R_out = ~q_out;
endmodule

module ro_stress_bank #(
    parameter int NUM_BANKS = 8,
    parameter int BANK_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NUM_BANKS-1:0]           bank_mask,
    input  logic                           ramp_en,
    input  logic [CNT_W-1:0]               on_cycles,
    input  logic [CNT_W-1:0]               off_cycles,
    input  logic [CNT_W-1:0]               burst_count,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_BANKS-1:0]           active_banks,
    output logic [CNT_W-1:0]               bursts_done,
    output logic [NUM_BANKS*BANK_SIZE-1:0] wire_inj
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_OFF  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [NUM_BANKS-1:0] r_active;
    logic [CNT_W-1:0]     r_bursts_done;
    logic [NUM_BANKS-1:0] r_mask;
    logic                 r_ramp;
    logic [CNT_W-1:0]     r_on_m1;
    logic [CNT_W-1:0]     r_off_m1;
    logic [CNT_W-1:0]     r_burst;
    logic [CNT_W-1:0]     r_cnt;

    logic [CNT_W-1:0]     w_on_in_m1;
    logic [CNT_W-1:0]     w_off_in_m1;
    logic [NUM_BANKS-1:0] w_in_low;
    logic [NUM_BANKS-1:0] w_mask_low;
    logic [NUM_BANKS-1:0] w_rem;
    logic [NUM_BANKS-1:0] w_rem_low;
    logic [CNT_W-1:0]     w_bursts_nx;
    logic [CNT_W-1:0]     w_cnt_m1;

    // Phase counters hold length-1 so a programmed 0 behaves as a single cycle.
    assign w_on_in_m1  = (on_cycles  == '0) ? '0 : on_cycles  - CNT_W'(1);
    assign w_off_in_m1 = (off_cycles == '0) ? '0 : off_cycles - CNT_W'(1);

    // x & -x isolates the lowest set bit: the next bank to bring up during ramp.
    assign w_in_low    = bank_mask & (~bank_mask + NUM_BANKS'(1));
    assign w_mask_low  = r_mask & (~r_mask + NUM_BANKS'(1));
    assign w_rem       = r_mask & ~r_active;
    assign w_rem_low   = w_rem & (~w_rem + NUM_BANKS'(1));
    assign w_bursts_nx = r_bursts_done + CNT_W'(1);
    assign w_cnt_m1    = r_cnt - CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_active      <= '0;
            r_bursts_done <= '0;
            r_mask        <= '0;
            r_ramp        <= 1'b0;
            r_on_m1       <= '0;
            r_off_m1      <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_mask        <= bank_mask;
                        r_ramp        <= ramp_en;
                        r_on_m1       <= w_on_in_m1;
                        r_off_m1      <= w_off_in_m1;
                        r_burst       <= burst_count;
                        r_bursts_done <= '0;
                        if (bank_mask == '0) begin
                            r_done <= 1'b1;
                        end else if (ramp_en) begin
                            r_state  <= S_RAMP;
                            r_busy   <= 1'b1;
                            r_active <= w_in_low;
                        end else begin
                            r_state  <= S_ON;
                            r_busy   <= 1'b1;
                            r_active <= bank_mask;
                            r_cnt    <= w_on_in_m1;
                        end
                    end
                end
                S_RAMP: begin
                    if (r_active == r_mask) begin
                        r_state <= S_ON;
                        r_cnt   <= r_on_m1;
                    end else begin
                        r_active <= r_active | w_rem_low;
                    end
                end
                S_ON: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_OFF;
                        r_active <= '0;
                        r_cnt    <= r_off_m1;
                    end else begin
                        r_cnt <= w_cnt_m1;
                    end
                end
                S_OFF: begin
                    if (r_cnt == '0) begin
                        r_bursts_done <= w_bursts_nx;
                        if (r_burst != '0 && w_bursts_nx == r_burst) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_ramp) begin
                            r_state  <= S_RAMP;
                            r_active <= w_mask_low;
                        end else begin
                            r_state  <= S_ON;
                            r_active <= r_mask;
                            r_cnt    <= r_on_m1;
                        end
                    end else begin
                        r_cnt <= w_cnt_m1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_active <= '0;
                end
            endcase

            // Abort overrides whatever the phase logic scheduled, including a pending burst increment.
            if (r_state != S_IDLE && stop) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_active      <= '0;
                r_done        <= 1'b1;
                r_bursts_done <= r_bursts_done;
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign active_banks = r_active;
    assign bursts_done  = r_bursts_done;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar k = 0; k < BANK_SIZE; k++) begin : g_cell
            ro_fanout u_ro (
                .R_in  (r_active[b]),
                .R_out (wire_inj[b*BANK_SIZE + k])
            );
        end
    end
endmodule
